// File: rtl/rv_iopmp_sram_checker.sv
// rv_iopmp_sram_checker: multi-channel IOPMP permission checker.
// The entry table lives in a single-port, registered-read SRAM array. Requesters
// are served one at a time through a round-robin arbiter. Entries are walked
// in index order, and the first matching entry decides the result.
// Optional error capture of the first denied access is enabled by defining
// IOPMP_ERR_CAPTURE_EN. The default build has no capture ports.
module rv_iopmp_sram_checker #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned SID_WIDTH      = 1,
  parameter int unsigned NUMBER_ENTRIES = 16,
  parameter int unsigned IDX_W          = $clog2(NUMBER_ENTRIES),
  localparam int unsigned NUMBER_MASTERS = 2 ** SID_WIDTH,
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic [NUM_CHANNELS-1:0]            req_valid_i,
  output logic [NUM_CHANNELS-1:0]            req_ready_o,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_CHANNELS*SID_WIDTH-1:0]  req_sid_i,
  input  logic [NUM_CHANNELS-1:0]            req_write_i,
  output logic [NUM_CHANNELS-1:0]            rsp_valid_o,
  input  logic [NUM_CHANNELS-1:0]            rsp_ready_i,
  output logic                               rsp_allow_o,
  input  logic                               ewr_en_i,
  input  logic [IDX_W-1:0]                   ewr_idx_i,
  input  logic [ADDR_WIDTH-1:0]              ewr_lo_i,
  input  logic [ADDR_WIDTH-1:0]              ewr_hi_i,
  input  logic                               ewr_r_i,
  input  logic                               ewr_w_i,
  input  logic [NUMBER_MASTERS-1:0]          ewr_sidmask_i,
`ifdef IOPMP_ERR_CAPTURE_EN
  output logic                               err_valid_o,
  output logic [CH_W-1:0]                    err_chan_o,
  output logic [ADDR_WIDTH-1:0]              err_addr_o,
  output logic [SID_WIDTH-1:0]               err_sid_o,
  output logic                               err_write_o,
  input  logic                               err_clr_i,
`endif
  output logic                               busy_o
);

  localparam int unsigned ENTRY_W = NUMBER_MASTERS + 2 + 2 * ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, CMP, RESP} state_t;

  state_t                    state, state_next;
  logic [CH_W-1:0]           rr_ptr, rr_next, gnt, gnt_sel, cand;
  logic                      gnt_found;
  logic [IDX_W-1:0]          idx;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [SID_WIDTH-1:0]      sid_q;
  logic                      write_q;
  logic                      allow_q;

  logic [ENTRY_W-1:0]        mem [NUMBER_ENTRIES];
  logic [ENTRY_W-1:0]        rd_data;
  logic [ADDR_WIDTH-1:0]     ent_lo, ent_hi;
  logic                      ent_r, ent_w, ent_match, last_idx;
  logic [NUMBER_MASTERS-1:0] ent_sidmask;

  assign ent_lo      = rd_data[ADDR_WIDTH-1:0];
  assign ent_hi      = rd_data[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign ent_w       = rd_data[2*ADDR_WIDTH];
  assign ent_r       = rd_data[2*ADDR_WIDTH+1];
  assign ent_sidmask = rd_data[ENTRY_W-1 -: NUMBER_MASTERS];
  // An empty entry (lo > hi) fails one of the two bound tests and so never matches.
  assign ent_match   = (ent_lo <= addr_q) && (addr_q <= ent_hi) && ent_sidmask[sid_q];
  assign last_idx    = (idx == IDX_W'(NUMBER_ENTRIES - 1));

  assign busy_o      = (state != IDLE);
  assign rsp_allow_o = (state == RESP) && allow_q && !rst_i;

  // Entry SRAM: a write takes the port and the walk read waits for the next cycle.
  always_ff @(posedge clk_i) begin
    if (ewr_en_i) begin
      mem[ewr_idx_i] <= {ewr_sidmask_i, ewr_r_i, ewr_w_i, ewr_hi_i, ewr_lo_i};
    end else if (state == READ) begin
      rd_data <= mem[idx];
    end
  end

  // Round-robin pick: the first requesting channel at or after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      cand = CH_W'((32'(rr_ptr) + i) % NUM_CHANNELS);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_sel   = cand;
      end
    end
    rr_next = CH_W'((32'(gnt_sel) + 32'd1) % NUM_CHANNELS);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next  = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state)
      IDLE: if (gnt_found) begin
        req_ready_o[gnt_sel] = 1'b1;
        state_next = enable_i ? READ : RESP;
      end
      READ: if (!ewr_en_i) state_next = CMP;
      CMP:  state_next = (ent_match || last_idx) ? RESP : READ;
      RESP: begin
        rsp_valid_o[gnt] = 1'b1;
        if (rsp_ready_i[gnt]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) begin
      req_ready_o = '0;
      rsp_valid_o = '0;
    end
  end

  // State register, request latch and walk/result bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      idx     <= '0;
      addr_q  <= '0;
      sid_q   <= '0;
      write_q <= 1'b0;
      allow_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (gnt_found) begin
          gnt     <= gnt_sel;
          rr_ptr  <= rr_next;
          addr_q  <= req_addr_i[32'(gnt_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          sid_q   <= req_sid_i[32'(gnt_sel)*SID_WIDTH +: SID_WIDTH];
          write_q <= req_write_i[gnt_sel];
          idx     <= '0;
          allow_q <= !enable_i;
        end
        CMP: begin
          if (ent_match)     allow_q <= write_q ? ent_w : ent_r;
          else if (last_idx) allow_q <= 1'b0;
          else               idx     <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IOPMP_ERR_CAPTURE_EN
  logic deny_fire;
  assign deny_fire = (state == RESP) && rsp_ready_i[gnt] && !allow_q;

  // Hold the first denied access until cleared. A deny arriving with the clear is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_chan_o  <= '0;
      err_addr_o  <= '0;
      err_sid_o   <= '0;
      err_write_o <= 1'b0;
    end else if (deny_fire && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_chan_o  <= gnt;
      err_addr_o  <= addr_q;
      err_sid_o   <= sid_q;
      err_write_o <= write_q;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rv_iopmp_sram_checker.sv
// Self-checking bench for rv_iopmp_sram_checker. It checks the DUT against a
// first-match table model that computes the result and the cycle count.
// Define IOPMP_ERR_CAPTURE_EN to also test the error-capture ports.
module tb_rv_iopmp_sram_checker;
  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 64;
  localparam int unsigned NE  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable;
  logic [NCH-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH-1:0]    req_sid;
  logic              rsp_allow, busy;
  logic              ewr_en, ewr_r, ewr_w;
  logic [3:0]        ewr_idx;
  logic [AW-1:0]     ewr_lo, ewr_hi;
  logic [1:0]        ewr_sidmask;
`ifdef IOPMP_ERR_CAPTURE_EN
  logic          err_valid, err_write, err_clr;
  logic [0:0]    err_chan, err_sid;
  logic [AW-1:0] err_addr;
`endif

  rv_iopmp_sram_checker #(
    .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .SID_WIDTH(1), .NUMBER_ENTRIES(NE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_sid_i(req_sid), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow),
    .ewr_en_i(ewr_en), .ewr_idx_i(ewr_idx), .ewr_lo_i(ewr_lo), .ewr_hi_i(ewr_hi),
    .ewr_r_i(ewr_r), .ewr_w_i(ewr_w), .ewr_sidmask_i(ewr_sidmask),
`ifdef IOPMP_ERR_CAPTURE_EN
    .err_valid_o(err_valid), .err_chan_o(err_chan), .err_addr_o(err_addr),
    .err_sid_o(err_sid), .err_write_o(err_write), .err_clr_i(err_clr),
`endif
    .busy_o(busy)
  );

  int total = 0;
  int bad   = 0;
  int rr_model = 0;

  logic [AW-1:0] m_lo [NE];
  logic [AW-1:0] m_hi [NE];
  bit            m_r [NE];
  bit            m_w [NE];
  logic [1:0]    m_mask [NE];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the first entry whose range and SID mask cover the access decides.
  function automatic void model(input logic [AW-1:0] a, input int unsigned sid, input bit wr,
                                output bit allow, output int hit);
    allow = 1'b0;
    hit   = -1;
    for (int k = 0; k < int'(NE); k++) begin
      if (hit < 0 && a >= m_lo[k] && a <= m_hi[k] && m_mask[k][sid] == 1'b1) begin
        allow = wr ? m_w[k] : m_r[k];
        hit   = k;
      end
    end
  endfunction

  task automatic write_entry(input int unsigned i, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                             input bit r, input bit w, input logic [1:0] mask);
    @(posedge clk); #1;
    ewr_en = 1'b1; ewr_idx = i[3:0]; ewr_lo = lo; ewr_hi = hi;
    ewr_r = r; ewr_w = w; ewr_sidmask = mask;
    @(posedge clk); #1;
    ewr_en = 1'b0;
    m_lo[i] = lo; m_hi[i] = hi; m_r[i] = r; m_w[i] = w; m_mask[i] = mask;
  endtask

  // One request on one channel. The ewr_* data must be preset when stall > 0.
  task automatic run_req(input int unsigned ch, input logic [AW-1:0] a, input int unsigned sid,
                         input bit wr, input bit en, input int unsigned stall, input bit jitter);
    bit exp_allow, got;
    int hit, exp_lat, lat;
    model(a, sid, wr, exp_allow, hit);
    if (!en) begin
      exp_allow = 1'b1;
      exp_lat   = 1;
    end else begin
      exp_lat = ((hit >= 0) ? 2 * hit + 3 : 2 * int'(NE) + 1) + int'(stall);
    end
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_addr[ch*AW +: AW] = a;
    req_sid[ch] = sid[0];
    req_write[ch] = wr;
    enable = en;
    got = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (req_ready[ch]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("grant_timeout", 64'(got), 64'd1);
      req_valid = '0;
      return;
    end
    check("grant", 64'(req_ready), 64'd1 << ch);
    rr_model = int'((ch + 1) % NCH);
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid = '0;
      if (jitter) enable = 1'($urandom_range(0, 1));
      ewr_en = (lat < int'(stall));
      @(negedge clk);
      lat++;
    end while (!rsp_valid[ch] && lat < 200);
    ewr_en = 1'b0;
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("rsp_valid", 64'(rsp_valid), 64'd1 << ch);
    check("rsp_allow", 64'(rsp_allow), 64'(exp_allow));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int cnt, exp;
    logic [AW-1:0] a;
    int unsigned e;

    rst = 1'b1; enable = 1'b1; req_valid = '1; req_write = '0; req_sid = '0;
    req_addr = '0; rsp_ready = '1; ewr_en = 1'b0; ewr_idx = '0; ewr_lo = '0;
    ewr_hi = '0; ewr_r = 1'b0; ewr_w = 1'b0; ewr_sidmask = '0;
`ifdef IOPMP_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_allow", 64'(rsp_allow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;

    // Empty table. lo > hi with full permissions must still never match.
    for (int unsigned i = 0; i < NE; i++) write_entry(i, 64'h100, 64'hFF, 1'b1, 1'b1, 2'b11);
    run_req(0, 64'h100, 0, 1'b0, 1'b1, 0, 1'b0);
    run_req(1, 64'hFF, 1, 1'b1, 1'b1, 0, 1'b0);

    // Entry 3 region, permissions, SID mask and bounds.
    write_entry(3, 64'h1000, 64'h1FFF, 1'b1, 1'b0, 2'b01);
    run_req(0, 64'h1800, 0, 1'b0, 1'b1, 0, 1'b0);
    run_req(0, 64'h1800, 0, 1'b1, 1'b1, 0, 1'b0);
    run_req(1, 64'h1800, 1, 1'b0, 1'b1, 0, 1'b0);
    run_req(0, 64'h1000, 0, 1'b0, 1'b1, 0, 1'b0);
    run_req(1, 64'h1FFF, 0, 1'b0, 1'b1, 0, 1'b0);
    run_req(0, 64'h0FFF, 0, 1'b0, 1'b1, 0, 1'b0);

    // First match wins.
    write_entry(0, 64'h2000, 64'h2000, 1'b0, 1'b1, 2'b11);
    write_entry(1, 64'h1F00, 64'h2FFF, 1'b1, 1'b1, 2'b11);
    run_req(0, 64'h2000, 0, 1'b0, 1'b1, 0, 1'b0);
    run_req(1, 64'h2001, 1, 1'b0, 1'b1, 0, 1'b0);

    // Bypass.
    run_req(1, 64'hDEAD_BEEF_0000_1234, 1, 1'b1, 1'b0, 0, 1'b0);

    // Five write cycles during READ of entry 0 stall the walk and install entry 5.
    ewr_idx = 4'd5; ewr_lo = 64'h5000; ewr_hi = 64'h5FFF; ewr_r = 1'b1; ewr_w = 1'b0;
    ewr_sidmask = 2'b01;
    m_lo[5] = 64'h5000; m_hi[5] = 64'h5FFF; m_r[5] = 1'b1; m_w[5] = 1'b0; m_mask[5] = 2'b01;
    run_req(0, 64'h5000, 0, 1'b0, 1'b1, 5, 1'b0);

    // Reset during a walk: no response, and the pointer returns to 0.
    @(posedge clk); #1;
    req_valid = 2'b01; req_addr[AW-1:0] = 64'h100; enable = 1'b1;
    got = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        got = 1'b1;
        break;
      end
    end
    check("midwalk_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midwalk_busy", 64'(busy), 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    check("midwalk_no_rsp", 64'(cnt), 64'd0);
    rr_model = 0;

    // Both channels held valid; a response held while rsp_ready is low.
    @(posedge clk); #1;
    enable = 1'b0; rsp_ready = '0; req_valid = '1;
    req_addr = {64'hAAAA, 64'h5555}; req_write = '0;
    for (int r = 0; r < 4; r++) begin
      exp = rr_model;
      got = 1'b0;
      for (int g = 0; g < 20; g++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          got = 1'b1;
          break;
        end
      end
      check("arb_grant", 64'(req_ready), got ? (64'd1 << exp) : 64'hFFFF);
      rr_model = (exp + 1) % int'(NCH);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("arb_hold_valid", 64'(rsp_valid), 64'd1 << exp);
        check("arb_hold_allow", 64'(rsp_allow), 64'd1);
        check("arb_no_grant", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = '1;
      @(posedge clk); #1;
      rsp_ready = '0;
      if (r == 3) req_valid = '0;
    end
    rsp_ready = '1;

    // Randomized tables and requests.
    for (int it = 0; it < 60; it++) begin
      if (it % 15 == 0) begin
        for (int unsigned i = 0; i < NE; i++) begin
          a = 64'($urandom_range(0, 16'hFFFF));
          if ($urandom_range(0, 4) == 0)
            write_entry(i, a + 64'd1, a, 1'($urandom), 1'($urandom), 2'($urandom));
          else
            write_entry(i, a, a + 64'($urandom_range(0, 16'h3000)),
                        1'($urandom), 1'($urandom), 2'($urandom));
        end
      end
      e = $urandom_range(0, NE - 1);
      case ($urandom_range(0, 5))
        0: a = m_lo[e];
        1: a = m_hi[e];
        2: a = m_hi[e] + 64'd1;
        3: a = m_lo[e] - 64'd1;
        default: a = 64'($urandom_range(0, 32'h12FFF));
      endcase
      run_req($urandom_range(0, NCH - 1), a, $urandom_range(0, 1), 1'($urandom),
              ($urandom_range(0, 6) != 0), 0, 1'b1);
    end

`ifdef IOPMP_ERR_CAPTURE_EN
    for (int unsigned i = 0; i < NE; i++) write_entry(i, 64'h100, 64'hFF, 1'b1, 1'b1, 2'b11);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared0", 64'(err_valid), 64'd0);
    run_req(0, 64'h40, 1, 1'b0, 1'b1, 0, 1'b0);
    run_req(1, 64'h80, 0, 1'b1, 1'b1, 0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("err_valid", 64'(err_valid), 64'd1);
    check("err_addr_first", err_addr, 64'h40);
    check("err_chan_first", 64'(err_chan), 64'd0);
    check("err_sid_first", 64'(err_sid), 64'd1);
    check("err_write_first", 64'(err_write), 64'd0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err_valid), 64'd0);
    run_req(1, 64'h80, 0, 1'b1, 1'b1, 0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("err_valid2", 64'(err_valid), 64'd1);
    check("err_addr_second", err_addr, 64'h80);
    check("err_chan_second", 64'(err_chan), 64'd1);
    check("err_write_second", 64'(err_write), 64'd1);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
